tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle cycles enforced between the end of one transmission and the next launch; legal range 1..65535.
REQ-002 Parameter TIMEOUT, default 200000: maximum cycles spent in WAIT_DONE before abort; legal range 2..2^20-1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 user_req  input  1  user request level; only its rising edge is a request.
REQ-006 user_byte  input  8  byte to send for a user request, sampled on the user_req rising edge.
REQ-007 r_DV  input  1  receiver data-valid strobe; every high cycle is a loopback request.
REQ-008 r_byte  input  8  received byte, sampled in every cycle where r_DV=1.
REQ-009 tx_done  input  1  transmitter completion strobe.
REQ-010 tx_start  output  1  one-cycle launch strobe to the transmitter.
REQ-011 tx_byte  output  8  byte presented to the transmitter; stable from LAUNCH until the next LAUNCH.
REQ-012 grant  output  2  one-hot owner of the transmission in flight: bit0 user, bit1 loopback; 00 otherwise.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 drop_count  output  8  count of overwritten loopback bytes, saturating.
REQ-015 err_timeout  output  1  sticky flag, set on a WAIT_DONE timeout.

Function
REQ-016 Two requester slots, each a pending flag plus an 8-bit holding register: slot U (user), slot L (loopback).
REQ-017 User edge detection: user_req registered once; request when user_req=1 and previous sample=0.
REQ-018 A user request while U pending is ignored; the held byte is unchanged.
REQ-019 r_DV=1 while L pending overwrites the L holding register with r_byte and increments drop_count; drop_count saturates at 255.
REQ-020 A capture and a slot clear in the same cycle leave the slot pending with the new byte.
REQ-021 FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
REQ-022 IDLE: if any slot is pending, select a winner, copy its byte to tx_byte, clear its pending flag, set grant, and go to LAUNCH; otherwise stay.
REQ-023 Round-robin: if both slots are pending, the winner is the slot not served last; if one slot is pending, it wins; the last-served pointer updates on each IDLE->LAUNCH.
REQ-024 LAUNCH lasts exactly one cycle, with tx_start=1, then goes to WAIT_DONE; tx_start=0 in all other states.
REQ-025 Latency: a request captured at the edge ending cycle k produces tx_start=1 in cycle k+2 when the FSM is IDLE in cycle k+1.
REQ-026 tx_done is sampled only in WAIT_DONE; tx_done=1 there clears grant to 00 and goes to GAP.
REQ-027 WAIT_DONE cycle counter: if TIMEOUT cycles elapse without tx_done, set err_timeout, clear grant, and go to GAP; the aborted byte is not retried.
REQ-028 GAP lasts exactly GAP_CYCLES cycles, then goes to IDLE; requests arriving in any non-IDLE state are captured into the slots per REQ-018..020.
REQ-029 The counters used for GAP and timeout are reset to 0 on every entry to their state.

Reset
REQ-030 rst_n=0 at a rising edge forces the following next cycle: state IDLE, both pending flags 0, both holding registers 0x00, tx_byte 0x00, tx_start 0, grant 00, busy 0, drop_count 0, err_timeout 0, last-served pointer = L (so U wins the first tie), and the user_req previous sample = 1.
REQ-031 A reset during a LAUNCH, WAIT_DONE or GAP state abandons the transmission; no tx_start occurs in the reset cycle or the cycle after it.
REQ-032 No request is captured in any cycle where rst_n=0.

Verification
REQ-033 Single loopback: r_DV=1 with r_byte=0x41 in cycle 10 -> tx_start=1 in cycle 12, tx_byte=0x41, grant=10; tx_done in cycle 50 -> grant=00, and IDLE is re-entered 16 cycles later.
REQ-034 Tie after reset: user rising edge (user_byte=0x55) and r_DV (0xAA) both captured in cycle 5 -> 0x55 is launched first; after its tx_done and GAP, 0xAA is launched with grant=10.
REQ-035 Overwrite: r_DV strobes 0x01, 0x02, 0x03 while the FSM is busy -> a single loopback launch of 0x03 follows, with drop_count=2.
REQ-036 Timeout: TIMEOUT=100, launch with no tx_done -> err_timeout=1 after 100 WAIT_DONE cycles, then GAP then IDLE; a later launch still occurs and err_timeout stays 1.
REQ-037 Held user_req: user_req held high for 1000 cycles -> exactly one user launch occurs.
REQ-038 Reset mid-WAIT_DONE: rst_n=0 for 1 cycle while grant=01 -> all outputs are at reset values next cycle, and no spurious tx_start occurs.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one byte transmitter between a user requester and a
// receiver loopback path. Round-robin between two holding slots, one-cycle
// launch strobe, completion wait with timeout, and an enforced idle gap.
module tx_arbiter #(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       user_req,
  input  logic [7:0] user_byte,
  input  logic       r_DV,
  input  logic [7:0] r_byte,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic [1:0] grant,
  output logic       busy,
  output logic [7:0] drop_count,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_e;

  localparam logic [15:0] GapLast     = 16'(GAP_CYCLES - 1);
  localparam logic [19:0] TimeoutLast = 20'(TIMEOUT - 1);

  state_e      state_q;
  logic        tx_start_q;
  logic [7:0]  tx_byte_q;
  logic [1:0]  grant_q;
  logic        busy_q;
  logic        err_q;
  logic        last_l_q;
  logic [15:0] gap_cnt_q;
  logic [19:0] wait_cnt_q;

  logic        user_prev_q;
  logic        u_pend_q, u_pend_d;
  logic        l_pend_q, l_pend_d;
  logic [7:0]  u_hold_q, u_hold_d;
  logic [7:0]  l_hold_q, l_hold_d;
  logic [7:0]  drop_q, drop_d;

  logic        user_rise;
  logic        pick_l;
  logic        serve_u;
  logic        serve_l;

  // Only the rising edge of the user level is a request.
  assign user_rise = user_req & ~user_prev_q;

  // Loopback wins when it is the only one pending, or on a tie when the user was served last.
  assign pick_l  = l_pend_q & (~u_pend_q | ~last_l_q);
  assign serve_l = (state_q == IDLE) & pick_l;
  assign serve_u = (state_q == IDLE) & u_pend_q & ~pick_l;

  assign tx_start    = tx_start_q;
  assign tx_byte     = tx_byte_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign drop_count  = drop_q;
  assign err_timeout = err_q;

  // Next state of both requester slots: a serve clears the slot, a capture in the same cycle re-arms it.
  always_comb begin
    u_pend_d = u_pend_q;
    u_hold_d = u_hold_q;
    l_pend_d = l_pend_q;
    l_hold_d = l_hold_q;
    drop_d   = drop_q;

    if (serve_u) begin
      u_pend_d = 1'b0;
    end
    if (user_rise && (!u_pend_q || serve_u)) begin
      u_pend_d = 1'b1;
      u_hold_d = user_byte;
    end

    if (serve_l) begin
      l_pend_d = 1'b0;
    end
    if (r_DV) begin
      l_pend_d = 1'b1;
      l_hold_d = r_byte;
      if (l_pend_q && !serve_l && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Slot registers and the user edge detector; reset suppresses any capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      user_prev_q <= 1'b1;
      u_pend_q    <= 1'b0;
      l_pend_q    <= 1'b0;
      u_hold_q    <= 8'h00;
      l_hold_q    <= 8'h00;
      drop_q      <= 8'h00;
    end else begin
      user_prev_q <= user_req;
      u_pend_q    <= u_pend_d;
      l_pend_q    <= l_pend_d;
      u_hold_q    <= u_hold_d;
      l_hold_q    <= l_hold_d;
      drop_q      <= drop_d;
    end
  end

  // Transmit sequencer: launch, wait for completion or timeout, then hold off for the gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      last_l_q   <= 1'b1;
      gap_cnt_q  <= 16'd0;
      wait_cnt_q <= 20'd0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (serve_u || serve_l) begin
            tx_byte_q  <= serve_l ? l_hold_q : u_hold_q;
            grant_q    <= serve_l ? 2'b10 : 2'b01;
            last_l_q   <= serve_l;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          wait_cnt_q <= 20'd0;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            grant_q   <= 2'b00;
            gap_cnt_q <= 16'd0;
            state_q   <= GAP;
          end else if (wait_cnt_q == TimeoutLast) begin
            err_q     <= 1'b1;
            grant_q   <= 2'b00;
            gap_cnt_q <= 16'd0;
            state_q   <= GAP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 20'd1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GapLast) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed table vectors plus hand-written multi-cycle
// sequences for tx_arbiter built with GAP_CYCLES=16 and TIMEOUT=100.
module tb_tx_arbiter;

  logic       clk;
  logic       rst_n;
  logic       user_req;
  logic [7:0] user_byte;
  logic       r_DV;
  logic [7:0] r_byte;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic [1:0] grant;
  logic       busy;
  logic [7:0] drop_count;
  logic       err_timeout;

  int numCompared = 0;
  int numFailed   = 0;

  typedef struct {
    logic       rstN;
    logic       userReq;
    logic [7:0] userByte;
    logic       rDv;
    logic [7:0] rByte;
    logic       txDone;
    int         reps;
    logic       expStart;
    logic [7:0] expByte;
    logic [1:0] expGrant;
    logic       expBusy;
    logic [7:0] expDrop;
    logic       expErr;
  } vec_t;

  vec_t vecs[8];

  tx_arbiter #(
    .GAP_CYCLES(16),
    .TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .user_req(user_req),
    .user_byte(user_byte),
    .r_DV(r_DV),
    .r_byte(r_byte),
    .tx_done(tx_done),
    .tx_start(tx_start),
    .tx_byte(tx_byte),
    .grant(grant),
    .busy(busy),
    .drop_count(drop_count),
    .err_timeout(err_timeout)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n     = v.rstN;
    user_req  = v.userReq;
    user_byte = v.userByte;
    r_DV      = v.rDv;
    r_byte    = v.rByte;
    tx_done   = v.txDone;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numCompared++;
    if (act !== exp) begin
      numFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    r_DV     = 1'b0;
    r_byte   = 8'h00;
    tx_done  = 1'b0;
    user_req = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitStart(input string name, input int budget);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, "_launch_seen"}, {31'd0, tx_start}, 32'd1);
  endtask

  task automatic countStarts(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_start === 1'b1) cnt++;
      tick();
    end
  endtask

  task automatic doneAfterLaunch();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;

    // Table: reset state, one user launch, completion, gap length, back to idle.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3,  1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1,  1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1,  1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1,  1'b1, 8'h3C, 2'b01, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5,  1'b0, 8'h3C, 2'b01, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1,  1'b0, 8'h3C, 2'b01, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16, 1'b0, 8'h3C, 2'b00, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2,  1'b0, 8'h3C, 2'b00, 1'b0, 8'h00, 1'b0};

    rst_n     = 1'b0;
    user_req  = 1'b0;
    user_byte = 8'h00;
    r_DV      = 1'b0;
    r_byte    = 8'h00;
    tx_done   = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        applyStimulus(vecs[i]);
        checkOutput($sformatf("v%0d.%0d_tx_start", i, r), {31'd0, tx_start}, {31'd0, vecs[i].expStart});
        checkOutput($sformatf("v%0d.%0d_tx_byte", i, r), {24'd0, tx_byte}, {24'd0, vecs[i].expByte});
        checkOutput($sformatf("v%0d.%0d_grant", i, r), {30'd0, grant}, {30'd0, vecs[i].expGrant});
        checkOutput($sformatf("v%0d.%0d_busy", i, r), {31'd0, busy}, {31'd0, vecs[i].expBusy});
        checkOutput($sformatf("v%0d.%0d_drop", i, r), {24'd0, drop_count}, {24'd0, vecs[i].expDrop});
        checkOutput($sformatf("v%0d.%0d_err", i, r), {31'd0, err_timeout}, {31'd0, vecs[i].expErr});
        tick();
      end
    end

    // Single loopback: two-cycle latency, then a 16-cycle gap after completion.
    doReset();
    tick();
    tick();
    r_DV   = 1'b1;
    r_byte = 8'h41;
    checkOutput("lb_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    r_DV = 1'b0;
    checkOutput("lb_k1_no_start", {31'd0, tx_start}, 32'd0);
    tick();
    checkOutput("lb_k2_start", {31'd0, tx_start}, 32'd1);
    checkOutput("lb_byte", {24'd0, tx_byte}, 32'h41);
    checkOutput("lb_grant", {30'd0, grant}, 32'd2);
    for (int i = 0; i < 30; i++) tick();
    tx_done = 1'b1;
    checkOutput("lb_grant_waiting", {30'd0, grant}, 32'd2);
    tick();
    tx_done = 1'b0;
    checkOutput("lb_grant_cleared", {30'd0, grant}, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checkOutput("lb_gap_len", n, 32'd16);

    // Tie right after reset: user goes first, loopback follows.
    doReset();
    tick();
    user_req  = 1'b1;
    user_byte = 8'h55;
    r_DV      = 1'b1;
    r_byte    = 8'hAA;
    tick();
    r_DV = 1'b0;
    tick();
    checkOutput("tie_first_byte", {24'd0, tx_byte}, 32'h55);
    checkOutput("tie_first_grant", {30'd0, grant}, 32'd1);
    doneAfterLaunch();
    waitStart("tie_second", 40);
    checkOutput("tie_second_byte", {24'd0, tx_byte}, 32'hAA);
    checkOutput("tie_second_grant", {30'd0, grant}, 32'd2);
    user_req = 1'b0;

    // Overwrite while busy, ignored second user edge, round-robin order.
    doReset();
    tick();
    user_req  = 1'b1;
    user_byte = 8'h9A;
    tick();
    tick();
    checkOutput("ow_first_byte", {24'd0, tx_byte}, 32'h9A);
    checkOutput("ow_first_grant", {30'd0, grant}, 32'd1);
    tick();
    r_DV = 1'b1;
    r_byte = 8'h01;
    tick();
    r_byte = 8'h02;
    tick();
    r_byte = 8'h03;
    tick();
    r_DV = 1'b0;
    user_req = 1'b0;
    tick();
    user_req = 1'b1;
    user_byte = 8'h11;
    tick();
    user_req = 1'b0;
    tick();
    user_req = 1'b1;
    user_byte = 8'h22;
    tick();
    user_req = 1'b0;
    checkOutput("ow_drop_mid", {24'd0, drop_count}, 32'd2);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    waitStart("ow_lb", 60);
    checkOutput("ow_lb_byte", {24'd0, tx_byte}, 32'h03);
    checkOutput("ow_lb_grant", {30'd0, grant}, 32'd2);
    checkOutput("ow_lb_drop", {24'd0, drop_count}, 32'd2);
    doneAfterLaunch();
    waitStart("ow_user", 60);
    checkOutput("ow_user_byte", {24'd0, tx_byte}, 32'h11);
    checkOutput("ow_user_grant", {30'd0, grant}, 32'd1);
    doneAfterLaunch();
    countStarts(40, cnt);
    checkOutput("ow_no_extra_launch", cnt, 32'd0);

    // Timeout after 100 waiting cycles; flag stays set across a later launch.
    doReset();
    r_DV = 1'b1;
    r_byte = 8'h77;
    tick();
    r_DV = 1'b0;
    tick();
    checkOutput("to_launch", {31'd0, tx_start}, 32'd1);
    tick();
    checkOutput("to_err_early", {31'd0, err_timeout}, 32'd0);
    n = 0;
    while (grant !== 2'b00 && n < 200) begin
      n++;
      tick();
    end
    checkOutput("to_wait_len", n, 32'd100);
    checkOutput("to_err_set", {31'd0, err_timeout}, 32'd1);
    checkOutput("to_busy_gap", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checkOutput("to_gap_len", n, 32'd16);
    user_req = 1'b1;
    user_byte = 8'h66;
    tick();
    user_req = 1'b0;
    waitStart("to_later", 10);
    checkOutput("to_later_byte", {24'd0, tx_byte}, 32'h66);
    checkOutput("to_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Held user level produces exactly one launch.
    doReset();
    tick();
    user_req = 1'b1;
    user_byte = 8'h5E;
    tx_done = 1'b1;
    countStarts(1000, cnt);
    checkOutput("held_one_launch", cnt, 32'd1);
    user_req = 1'b0;
    tx_done = 1'b0;

    // Reset while waiting: reset outputs next cycle, nothing launches afterwards.
    doReset();
    tick();
    user_req = 1'b1;
    user_byte = 8'hC3;
    tick();
    tick();
    tick();
    checkOutput("rw_grant_before", {30'd0, grant}, 32'd1);
    rst_n = 1'b0;
    r_DV = 1'b1;
    r_byte = 8'hEE;
    tick();
    rst_n = 1'b1;
    r_DV = 1'b0;
    checkOutput("rw_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("rw_tx_byte", {24'd0, tx_byte}, 32'd0);
    checkOutput("rw_grant", {30'd0, grant}, 32'd0);
    checkOutput("rw_busy", {31'd0, busy}, 32'd0);
    checkOutput("rw_drop", {24'd0, drop_count}, 32'd0);
    checkOutput("rw_err", {31'd0, err_timeout}, 32'd0);
    countStarts(30, cnt);
    checkOutput("rw_no_launch", cnt, 32'd0);
    user_req = 1'b0;

    // Capture in the same cycle the slot is served keeps the new byte pending.
    doReset();
    r_DV = 1'b1;
    r_byte = 8'h5A;
    tick();
    r_byte = 8'h6B;
    tick();
    r_DV = 1'b0;
    checkOutput("cc_first_byte", {24'd0, tx_byte}, 32'h5A);
    checkOutput("cc_first_grant", {30'd0, grant}, 32'd2);
    checkOutput("cc_drop", {24'd0, drop_count}, 32'd0);
    doneAfterLaunch();
    waitStart("cc_second", 40);
    checkOutput("cc_second_byte", {24'd0, tx_byte}, 32'h6B);
    checkOutput("cc_second_drop", {24'd0, drop_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numFailed);
    $finish;
  end

endmodule
